// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops plus an optional
// shift-add multiplier that takes WIDTH iterations, with an NZCV flag register.
module alu_mc #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       ALUControl,
  input  logic             SetFlags,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [WIDTH-1:0] ALUResult,
  output logic [3:0]       ALUFlags,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL  = 1'b1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ORR = 3'b011;
  localparam logic [2:0] OP_EOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_ADC = 3'b110;

  localparam int CW = $clog2(WIDTH);

  logic [0:0]       state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [WIDTH-1:0] acc_reg;
  logic             sf_reg;
  logic [WIDTH-1:0] result_reg;
  logic [3:0]       flags_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             is_mul;
  logic [WIDTH-1:0] b_op;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_next;
  logic [3:0]       flags_next;
  logic [WIDTH-1:0] acc_next;
  logic [3:0]       mul_flags;

  assign is_mul = MUL_EN && (ALUControl == OP_MUL);

  // SUB is A + ~B + 1 so the adder carry-out directly gives not-borrow.
  always_comb begin
    b_op = SrcB;
    cin  = 1'b0;
    if (ALUControl == OP_SUB) begin
      b_op = ~SrcB;
      cin  = 1'b1;
    end else if (ALUControl == OP_ADC) begin
      cin = flags_reg[1];
    end
  end

  assign sum = {1'b0, SrcA} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};

  always_comb begin
    res_next   = result_reg;
    flags_next = flags_reg;
    case (ALUControl)
      OP_ADD, OP_SUB, OP_ADC: begin
        res_next   = sum[WIDTH-1:0];
        flags_next = {sum[WIDTH-1], (sum[WIDTH-1:0] == '0), sum[WIDTH],
                      (SrcA[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != SrcA[WIDTH-1])};
      end
      OP_AND: res_next = SrcA & SrcB;
      OP_ORR: res_next = SrcA | SrcB;
      OP_EOR: res_next = SrcA ^ SrcB;
      default: res_next = result_reg;
    endcase
    if (ALUControl == OP_AND || ALUControl == OP_ORR || ALUControl == OP_EOR)
      flags_next = {res_next[WIDTH-1], (res_next == '0), flags_reg[1:0]};
    if (!SetFlags)
      flags_next = flags_reg;
  end

  // One shift-add step; on the final step this sum is the product itself.
  assign acc_next  = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign mul_flags = {acc_next[WIDTH-1], (acc_next == '0), flags_reg[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      sf_reg     <= 1'b0;
      result_reg <= '0;
      flags_reg  <= 4'b0000;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (is_mul) begin
              mcand_reg  <= SrcA;
              mplier_reg <= SrcB;
              acc_reg    <= '0;
              cnt_reg    <= '0;
              sf_reg     <= SetFlags;
              state_reg  <= MUL;
              busy_reg   <= 1'b1;
            end else begin
              result_reg <= res_next;
              flags_reg  <= flags_next;
              done_reg   <= 1'b1;
            end
          end
        end
        MUL: begin
          acc_reg    <= acc_next;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          if (cnt_reg == CW'(WIDTH - 1)) begin
            result_reg <= acc_next;
            if (sf_reg)
              flags_reg <= mul_flags;
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ALUResult = result_reg;
  assign ALUFlags  = flags_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc (WIDTH=32): a reference model pushes expected
// result/flags on each accepted start and they are popped when done pulses.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  ALUControl;
  logic        SetFlags;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [31:0] ALUResult;
  logic [3:0]  ALUFlags;
  logic        busy;
  logic        done;

  alu_mc #(.WIDTH(32), .MUL_EN(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ALUControl (ALUControl),
    .SetFlags   (SetFlags),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ALUResult  (ALUResult),
    .ALUFlags   (ALUFlags),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_result = '0;
  logic [3:0]  m_flags  = 4'b0000;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: updates bench-side result/flags and queues the expectation.
  task automatic push_exp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic sf);
    logic [32:0] s;
    logic [63:0] p;
    logic [31:0] r;
    logic        c;
    logic        v;
    exp_t        e;
    r = m_result;
    c = m_flags[1];
    v = m_flags[0];
    case (op)
      3'b000: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; c = s[32]; v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'b001: begin
        r = a - b; c = (a >= b); v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'b110: begin
        s = {1'b0, a} + {1'b0, b} + {32'b0, m_flags[1]};
        r = s[31:0]; c = s[32]; v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b100: r = a ^ b;
      3'b101: begin
        p = {32'b0, a} * {32'b0, b};
        r = p[31:0];
      end
      default: ;
    endcase
    if (op != 3'b111) begin
      m_result = r;
      if (sf) m_flags = {r[31], (r == 32'd0), c, v};
    end
    e.res = m_result;
    e.flg = m_flags;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic sf);
    ALUControl = op;
    SrcA       = a;
    SrcB       = b;
    SetFlags   = sf;
    start      = 1'b1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic sf);
    drive(op, a, b, sf);
    push_exp(op, a, b, sf);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    chk({tag, "_done"}, done, 1'b1);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 1'b1, 1'b0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_res"}, ALUResult, e.res);
      chk({tag, "_flags"}, ALUFlags, e.flg);
    end
    $display("txn %s: result=%h flags=%b", tag, ALUResult, ALUFlags);
  endtask

  // Single-cycle op: issue, check the result one edge later, then confirm done fell.
  task automatic single(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic sf);
    issue(op, a, b, sf);
    step();
    start = 1'b0;
    check_out(tag);
    step();
    chk({tag, "_done_fall"}, done, 1'b0);
  endtask

  int cyc;
  int stray_done;

  initial begin
    reset = 1'b0; start = 1'b0; ALUControl = 3'b000; SetFlags = 1'b0;
    SrcA = '0; SrcB = '0;
    #3;
    chk("rst_result", ALUResult, 32'd0);
    chk("rst_flags", ALUFlags, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    step(); step();
    reset = 1'b1;

    single("add_ovf", 3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
    chk("add_ovf_const", {ALUResult, ALUFlags}, {32'h8000_0000, 4'b1001});

    single("sub_eq", 3'b001, 32'd5, 32'd5, 1'b1);
    chk("sub_eq_flags_const", ALUFlags, 4'b0110);
    single("sub_borrow", 3'b001, 32'd0, 32'd1, 1'b1);
    chk("sub_borrow_const", {ALUResult, ALUFlags}, {32'hFFFF_FFFF, 4'b1000});

    single("add_carry", 3'b000, 32'hFFFF_FFFF, 32'h1, 1'b1);
    chk("add_carry_flags_const", ALUFlags, 4'b0110);
    single("adc", 3'b110, 32'd1, 32'd1, 1'b1);
    chk("adc_res_const", ALUResult, 32'd3);
    single("and_zero", 3'b010, 32'hF0, 32'h0F, 1'b1);
    chk("and_flags_const", ALUFlags, 4'b0100);

    single("sub_noflags", 3'b001, 32'h8000_0000, 32'd1, 1'b0);
    single("reserved", 3'b111, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    single("sub_neg", 3'b001, 32'h8000_0000, 32'd1, 1'b1);

    // Back-to-back single-cycle ops on consecutive edges.
    issue(3'b011, 32'hA500_0000, 32'h0000_005A, 1'b1);
    step();
    check_out("b2b_orr");
    issue(3'b100, 32'hFFFF_0000, 32'hFFFF_0000, 1'b1);
    step();
    check_out("b2b_eor");
    issue(3'b000, 32'h8000_0000, 32'h8000_0000, 1'b1);
    step();
    start = 1'b0;
    check_out("b2b_add");
    step();
    chk("b2b_done_fall", done, 1'b0);

    // Multiply with an ignored start partway through and operand changes.
    issue(3'b101, 32'h0001_0003, 32'h0000_0005, 1'b1);
    step();
    start = 1'b0;
    chk("mul_busy_rise", busy, 1'b1);
    cyc = 0;
    stray_done = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      if (done !== 1'b0) stray_done++;
      if (cyc == 5) drive(3'b000, 32'hFFFF_FFFF, 32'h1, 1'b1);
      else begin
        start = 1'b0;
        if (cyc == 6) drive(3'b010, 32'h0, 32'h0, 1'b0);
        start = 1'b0;
      end
      step();
    end
    chk("mul_busy_cycles", cyc, 32'd32);
    chk("mul_stray_done", stray_done, 32'd0);
    check_out("mul");
    chk("mul_res_const", ALUResult, 32'h0005_000F);

    // Start during the done cycle is accepted.
    issue(3'b000, 32'd10, 32'd20, 1'b0);
    step();
    start = 1'b0;
    check_out("add_after_mul");
    step();
    chk("ignored_start_no_done", done, 1'b0);

    issue(3'b101, 32'h0001_0000, 32'h0001_0000, 1'b1);
    step();
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      cyc++;
      step();
    end
    chk("mul_zero_latency", cyc, 32'd32);
    check_out("mul_zero");

    // Abort a multiply with reset at iteration 10.
    issue(3'b101, 32'h1234_5678, 32'h0000_0007, 1'b1);
    step();
    start = 1'b0;
    repeat (10) step();
    chk("abort_busy_pre", busy, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    sb_q.delete();
    m_result = '0;
    m_flags  = 4'b0000;
    chk("abort_result", ALUResult, 32'd0);
    chk("abort_flags", ALUFlags, 4'b0000);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    step(); step();
    chk("abort_hold_done", done, 1'b0);
    reset = 1'b1;
    single("add_post_reset", 3'b000, 32'd2, 32'd3, 1'b1);
    chk("add_post_reset_const", ALUResult, 32'd5);
    step();
    chk("post_reset_idle_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
